// File: rtl/aes_decipher_block.sv
// Iterative AES-128/256 inverse cipher: one round per five cycles, inverse S-box shared externally.
// Optional busy-command error pulse on cmd_err enabled by AES_DECIPHER_CMD_ERR_EN.
module aes_decipher_block (
   input  logic         clk,
   input  logic         reset,
   input  logic         next_cmd,
   input  logic         keylen,
   output logic [3:0]   round,
   input  logic [127:0] round_key,
   output logic [31:0]  inv_sboxw,
   input  logic [31:0]  new_inv_sboxw,
   input  logic [127:0] block_msg,
   output logic [127:0] new_block,
   output logic         ready,
   output logic         cmd_err
);

   localparam int unsigned ROUND_W = 4;
   localparam logic [ROUND_W-1:0] NR_128 = ROUND_W'(10);
   localparam logic [ROUND_W-1:0] NR_256 = ROUND_W'(14);

   typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

   state_t             state;
   logic [1:0]         sword_ctr;
   logic               keylen_reg;
   logic [ROUND_W-1:0] round_ctr;
   logic [127:0]       add_key;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply-by-{0e,0b,0d,09} built from xtime chains
   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a [4];
      logic [7:0] m09 [4];
      logic [7:0] m0b [4];
      logic [7:0] m0d [4];
      logic [7:0] m0e [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]   = c[31-8*i -: 8];
         x2     = xt(a[i]);
         x4     = xt(x2);
         x8     = xt(x4);
         m09[i] = x8 ^ a[i];
         m0b[i] = x8 ^ x2 ^ a[i];
         m0d[i] = x8 ^ x4 ^ a[i];
         m0e[i] = x8 ^ x4 ^ x2;
      end
      return {m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3],
              m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3],
              m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3],
              m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3]};
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] b);
      return {inv_mix_col(b[127:96]), inv_mix_col(b[95:64]),
              inv_mix_col(b[63:32]),  inv_mix_col(b[31:0])};
   endfunction

   // Row r rotates right by r columns
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] b);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-32*c-8*r -: 8] = b[127-32*((c-r+4)%4)-8*r -: 8];
      return o;
   endfunction

   assign round   = round_ctr;
   assign add_key = new_block ^ round_key;

   always_comb begin
      inv_sboxw = '0;
      if (state == SBOX) begin
         case (sword_ctr)
            2'd0:    inv_sboxw = new_block[127:96];
            2'd1:    inv_sboxw = new_block[95:64];
            2'd2:    inv_sboxw = new_block[63:32];
            default: inv_sboxw = new_block[31:0];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         sword_ctr  <= '0;
         keylen_reg <= 1'b0;
         round_ctr  <= '0;
         new_block  <= '0;
         ready      <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (next_cmd) begin
                  keylen_reg <= keylen;
                  round_ctr  <= keylen ? NR_256 : NR_128;
                  ready      <= 1'b0;
                  state      <= INIT;
               end
            end
            INIT: begin
               new_block <= inv_shift_rows(block_msg ^ round_key);
               round_ctr <= (keylen_reg ? NR_256 : NR_128) - ROUND_W'(1);
               sword_ctr <= '0;
               state     <= SBOX;
            end
            SBOX: begin
               case (sword_ctr)
                  2'd0:    new_block[127:96] <= new_inv_sboxw;
                  2'd1:    new_block[95:64]  <= new_inv_sboxw;
                  2'd2:    new_block[63:32]  <= new_inv_sboxw;
                  default: new_block[31:0]   <= new_inv_sboxw;
               endcase
               sword_ctr <= sword_ctr + 2'd1;
               if (sword_ctr == 2'd3)
                  state <= MAIN;
            end
            MAIN: begin
               if (round_ctr != '0) begin
                  new_block <= inv_shift_rows(inv_mix_columns(add_key));
                  round_ctr <= round_ctr - ROUND_W'(1);
                  state     <= SBOX;
               end else begin
                  new_block <= add_key;
                  ready     <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef AES_DECIPHER_CMD_ERR_EN
   logic cmd_err_reg;

   always_ff @(posedge clk) begin
      if (reset)
         cmd_err_reg <= 1'b0;
      else
         cmd_err_reg <= next_cmd && (state != IDLE);
   end

   assign cmd_err = cmd_err_reg;
`else
   assign cmd_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_decipher_block.sv
// Directed FIPS-197 C.1/C.3 decryption bench with its own S-box, key schedule and timing model.
module tb_aes_decipher_block;

   logic         clk = 1'b0;
   logic         reset;
   logic         next_cmd;
   logic         keylen;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic [31:0]  inv_sboxw;
   logic [31:0]  new_inv_sboxw;
   logic [127:0] block_msg;
   logic [127:0] new_block;
   logic         ready;
   logic         cmd_err;

   logic [7:0]   sbox_t [256];
   logic [7:0]   inv_t  [256];
   logic [127:0] rk128  [15];
   logic [127:0] rk256  [15];
   logic         key_sel;
   logic [127:0] prev_block;

   int errors = 0;
   int checks = 0;

   localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] KEY   =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   always #5 clk = ~clk;

   aes_decipher_block dut (
      .clk(clk), .reset(reset), .next_cmd(next_cmd), .keylen(keylen),
      .round(round), .round_key(round_key), .inv_sboxw(inv_sboxw),
      .new_inv_sboxw(new_inv_sboxw), .block_msg(block_msg),
      .new_block(new_block), .ready(ready), .cmd_err(cmd_err)
   );

   assign round_key     = key_sel ? rk256[round] : rk128[round];
   assign new_inv_sboxw = {inv_t[inv_sboxw[31:24]], inv_t[inv_sboxw[23:16]],
                           inv_t[inv_sboxw[15:8]],  inv_t[inv_sboxw[7:0]]};

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   task automatic build_tables();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sbox_t[x] = s;
         inv_t[s]  = 8'(x);
      end
   endtask

   task automatic expand(input int nk, output logic [127:0] rk [15]);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rcon;
      int          nr;
      nr   = nk + 6;
      rcon = 8'h01;
      for (int i = 0; i < 15; i++) rk[i] = '0;
      for (int i = 0; i < nk; i++) w[i] = KEY[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end else if (nk == 8 && i % nk == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_ready"}, 128'(ready), 128'(1));
      check({tag, "_block"}, new_block, 128'(0));
      check({tag, "_round"}, 128'(round), 128'(0));
      check({tag, "_sboxw"}, 128'(inv_sboxw), 128'(0));
      check({tag, "_cmd_err"}, 128'(cmd_err), 128'(0));
   endtask

   // Call just after a clock edge (edge 0); the command is sampled at edge 1.
   task automatic run_op(input logic [127:0] ct, input logic kl, input logic [127:0] pt,
                         input int busy_at, input int reset_at);
      int   nr, lat, c;
      bit   done;
      logic exp_err;
      nr   = kl ? 14 : 10;
      lat  = 2 + 5*nr;
      c    = 0;
      done = 0;
      block_msg = ct;
      keylen    = kl;
      key_sel   = kl;
      next_cmd  = 1'b1;
      while (!done && c < lat + 10) begin
         @(posedge clk);
         #1;
         c++;
         if (c == 1) begin
            next_cmd = 1'b0;
            check("hold_until_init", new_block, prev_block);
            check("round_init", 128'(round), 128'(nr));
            check("sboxw_init", 128'(inv_sboxw), 128'(0));
         end
         if (c >= 6 && (c - 6) % 5 == 0 && c <= 1 + 5*nr) begin
            check("round_main", 128'(round), 128'(nr - 1 - (c - 6) / 5));
            check("sboxw_main", 128'(inv_sboxw), 128'(0));
         end
         exp_err = 1'b0;
`ifdef AES_DECIPHER_CMD_ERR_EN
         exp_err = (busy_at > 0) && (c == busy_at + 1);
`endif
         check("cmd_err", 128'(cmd_err), 128'(exp_err));
         if (busy_at > 0 && c == busy_at) begin
            next_cmd = 1'b1;
            keylen   = ~kl;
         end
         if (busy_at > 0 && c == busy_at + 1) next_cmd = 1'b0;
         if (reset_at > 0 && c == reset_at - 1) reset = 1'b1;
         if (reset_at > 0 && c == reset_at) begin
            reset = 1'b0;
            reset_checks("mid_reset");
            prev_block = '0;
            return;
         end
         if (ready) done = 1;
      end
      check("latency", 128'(c), 128'(lat));
      check("plaintext", new_block, pt);
      prev_block = pt;
   endtask

   initial begin
      reset     = 1'b1;
      next_cmd  = 1'b0;
      keylen    = 1'b0;
      block_msg = '0;
      key_sel   = 1'b0;
      build_tables();
      expand(4, rk128);
      expand(8, rk256);
      repeat (2) @(posedge clk);
      #1;
      reset_checks("por");
      reset      = 1'b0;
      prev_block = '0;
      @(posedge clk);
      #1;

      run_op(CT_C1, 1'b0, PT, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      run_op(CT_C3, 1'b1, PT, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      run_op(CT_C1, 1'b0, PT, 20, 0);
      repeat (3) @(posedge clk);
      #1;
      run_op(CT_C3, 1'b1, PT, 0, 30);
      run_op(CT_C1, 1'b0, PT, 0, 0);
      run_op(CT_C3, 1'b1, PT, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
